// File: rtl/alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// alu_muldiv_seq
//
// Multi-cycle 8x8 unsigned multiply / 8/8 unsigned divide sequencer. It owns
// the shared combinational 8-bit ALU while a command runs and steps it once
// per clock: ADD for shift-add multiply, SUB for restoring divide.
//
// Command side (valid/ready):
//   cmd_valid / cmd_ready   handshake; accepted only in IDLE
//   cmd_op                  0 = multiply, 1 = divide
//   cmd_a, cmd_b            multiplicand/multiplier or dividend/divisor
// Response side (valid/ready):
//   rsp_valid / rsp_ready   handshake; fields held until taken
//   rsp_hi                  product[15:8] or remainder
//   rsp_lo                  product[7:0]  or quotient
//   rsp_dz                  divide-by-zero flag
// ALU side:
//   alu_ina, alu_inb        operands (0 outside RUN)
//   alu_operation           opcode (OP_IDLE outside RUN)
//   alu_shamt               shift amount, always 0
//   alu_out, alu_cr         ALU result and carry / no-borrow flag
//
// Configuration macro:
//   MULDIV_ZERO_SKIP_EN     multiply with a zero operand completes on the
//                           accept edge instead of running 8 steps.
// ---------------------------------------------------------------------------
module alu_muldiv_seq #(
  parameter logic [3:0] OP_ADD  = 4'b0010,
  parameter logic [3:0] OP_SUB  = 4'b0110,
  parameter logic [3:0] OP_IDLE = 4'b0000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic       cmd_op,
  input  logic [7:0] cmd_a,
  input  logic [7:0] cmd_b,
  output logic       rsp_valid,
  input  logic       rsp_ready,
  output logic [7:0] rsp_hi,
  output logic [7:0] rsp_lo,
  output logic       rsp_dz,
  output logic [7:0] alu_ina,
  output logic [7:0] alu_inb,
  output logic [3:0] alu_operation,
  output logic [4:0] alu_shamt,
  input  logic [7:0] alu_out,
  input  logic       alu_cr
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q,   cnt_d;
  logic       op_q,    op_d;    // 0 = multiply, 1 = divide
  logic [7:0] acc_q,   acc_d;   // multiply accumulator / divide remainder
  logic [7:0] q_q,     q_d;     // multiplier shifting into product lo / quotient
  logic [7:0] m_q,     m_d;     // multiplicand / divisor
  logic       dz_q,    dz_d;

  // Divide working value: remainder shifted left with the next dividend bit.
  logic [7:0] div_shift;
  logic       take;

  assign div_shift = {acc_q[6:0], q_q[7]};

  // -------------------------------------------------------------------------
  // State and datapath registers
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      op_q    <= 1'b0;
      acc_q   <= '0;
      q_q     <= '0;
      m_q     <= '0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      acc_q   <= acc_d;
      q_q     <= q_d;
      m_q     <= m_d;
      dz_q    <= dz_d;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state, datapath step and ALU drive
  // -------------------------------------------------------------------------
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    op_d          = op_q;
    acc_d         = acc_q;
    q_d           = q_q;
    m_d           = m_q;
    dz_d          = dz_q;
    take          = 1'b0;
    alu_operation = OP_IDLE;
    alu_ina       = '0;
    alu_inb       = '0;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d  = cmd_op;
          cnt_d = '0;
          dz_d  = 1'b0;
          acc_d = '0;
          if (cmd_op) begin
            // Divide: q holds the dividend, m the divisor.
            q_d = cmd_a;
            m_d = cmd_b;
            if (cmd_b == 8'd0) begin
              // Divide-by-zero answers immediately: all-ones quotient,
              // dividend returned as remainder.
              dz_d    = 1'b1;
              acc_d   = cmd_a;
              q_d     = 8'hFF;
              state_d = S_DONE;
            end else begin
              state_d = S_RUN;
            end
          end else begin
            // Multiply: q holds the multiplier, m the multiplicand.
            q_d = cmd_b;
            m_d = cmd_a;
`ifdef MULDIV_ZERO_SKIP_EN
            if ((cmd_a == 8'd0) || (cmd_b == 8'd0)) begin
              q_d     = '0;
              state_d = S_DONE;
            end else begin
              state_d = S_RUN;
            end
`else
            state_d = S_RUN;
`endif
          end
        end
      end

      S_RUN: begin
        if (!op_q) begin
          // Shift-add: add the multiplicand when the current multiplier bit
          // is set, then shift {carry, sum, q} right by one. Product low
          // bits migrate into q as the multiplier bits drain out.
          alu_operation = OP_ADD;
          alu_ina       = acc_q;
          alu_inb       = q_q[0] ? m_q : '0;
          acc_d         = {alu_cr, alu_out[7:1]};
          q_d           = {alu_out[0], q_q[7:1]};
        end else begin
          // Restoring divide. When the old remainder's top bit is set the
          // shifted value is >= 256 > divisor, so subtraction always wins
          // and the 8-bit ALU result is the correct wrapped remainder.
          alu_operation = OP_SUB;
          alu_ina       = div_shift;
          alu_inb       = m_q;
          take          = acc_q[7] | alu_cr;
          acc_d         = take ? alu_out : div_shift;
          q_d           = {q_q[6:0], take};
        end
        cnt_d = cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          state_d = S_DONE;
        end
      end

      S_DONE: begin
        if (rsp_ready) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // -------------------------------------------------------------------------
  // Handshake and response outputs
  // -------------------------------------------------------------------------
  // Gated with rst so the block never advertises readiness while held in reset.
  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign rsp_valid = (state_q == S_DONE);
  assign rsp_hi    = acc_q;
  assign rsp_lo    = q_q;
  assign rsp_dz    = dz_q;
  assign alu_shamt = '0;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
// ---------------------------------------------------------------------------
// tb_alu_muldiv_seq
//
// Self-checking bench for alu_muldiv_seq. Supplies a behavioural 8-bit ALU,
// runs directed and random multiply/divide commands and compares every
// response against plain-arithmetic expectations (a*b, a/b, a%b).
// ---------------------------------------------------------------------------
module tb_alu_muldiv_seq;

  localparam logic [3:0] OP_ADD  = 4'b0010;
  localparam logic [3:0] OP_SUB  = 4'b0110;
  localparam logic [3:0] OP_IDLE = 4'b0000;

  logic       clk;
  logic       rst;
  logic       cmd_valid;
  logic       cmd_ready;
  logic       cmd_op;
  logic [7:0] cmd_a;
  logic [7:0] cmd_b;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [7:0] rsp_hi;
  logic [7:0] rsp_lo;
  logic       rsp_dz;
  logic [7:0] alu_ina;
  logic [7:0] alu_inb;
  logic [3:0] alu_operation;
  logic [4:0] alu_shamt;
  logic [7:0] alu_out;
  logic       alu_cr;

  int n_checks;
  int n_fail;

  alu_muldiv_seq #(
    .OP_ADD (OP_ADD),
    .OP_SUB (OP_SUB),
    .OP_IDLE(OP_IDLE)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .cmd_valid    (cmd_valid),
    .cmd_ready    (cmd_ready),
    .cmd_op       (cmd_op),
    .cmd_a        (cmd_a),
    .cmd_b        (cmd_b),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_hi       (rsp_hi),
    .rsp_lo       (rsp_lo),
    .rsp_dz       (rsp_dz),
    .alu_ina      (alu_ina),
    .alu_inb      (alu_inb),
    .alu_operation(alu_operation),
    .alu_shamt    (alu_shamt),
    .alu_out      (alu_out),
    .alu_cr       (alu_cr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Behavioural shared ALU.
  always_comb begin
    logic [8:0] sum;
    sum     = {1'b0, alu_ina} + {1'b0, alu_inb};
    alu_out = alu_ina & alu_inb;
    alu_cr  = 1'b0;
    case (alu_operation)
      OP_ADD: begin
        alu_out = sum[7:0];
        alu_cr  = sum[8];
      end
      OP_SUB: begin
        alu_out = alu_ina - alu_inb;
        alu_cr  = (alu_ina >= alu_inb);
      end
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // One complete transaction: issue, wait for response, hold it for
  // hold_cyc cycles with rsp_ready low while poking cmd_valid, then take it.
  task automatic run_cmd(input logic op, input logic [7:0] a, input logic [7:0] b,
                         input int hold_cyc);
    logic [15:0] prod;
    logic [7:0]  exp_hi, exp_lo;
    logic        exp_dz;
    int          exp_lat, n, w;
    logic [3:0]  exp_opc;
    logic        op_ok, stable;

    // Reference behaviour from the arithmetic definition.
    exp_dz  = 1'b0;
    exp_lat = 8;
    if (!op) begin
      prod    = 16'(a) * 16'(b);
      exp_hi  = prod[15:8];
      exp_lo  = prod[7:0];
      exp_opc = OP_ADD;
`ifdef MULDIV_ZERO_SKIP_EN
      if (a == 8'd0 || b == 8'd0) exp_lat = 0;
`endif
    end else begin
      exp_opc = OP_SUB;
      if (b == 8'd0) begin
        exp_dz  = 1'b1;
        exp_hi  = a;
        exp_lo  = 8'hFF;
        exp_lat = 0;
      end else begin
        exp_hi = a % b;
        exp_lo = a / b;
      end
    end

    w = 0;
    while (!cmd_ready && w < 20) begin
      @(posedge clk); #1;
      w++;
    end
    check_eq("cmd_ready_before_issue", 16'(cmd_ready), 16'd1);

    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_a     = a;
    cmd_b     = b;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    // Scramble inputs so a design that fails to latch operands shows it.
    cmd_valid = 1'b0;
    cmd_op    = 1'($urandom);
    cmd_a     = 8'($urandom);
    cmd_b     = 8'($urandom);

    n     = 0;
    op_ok = 1'b1;
    while (!rsp_valid && n < 20) begin
      if (alu_operation !== exp_opc || alu_shamt !== 5'd0) op_ok = 1'b0;
      @(posedge clk); #1;
      n++;
    end
    check_eq("latency", 16'(n), 16'(exp_lat));
    if (exp_lat != 0) check_eq("run_opcode", 16'(op_ok), 16'd1);
    check_eq("rsp_hi", 16'(rsp_hi), 16'(exp_hi));
    check_eq("rsp_lo", 16'(rsp_lo), 16'(exp_lo));
    check_eq("rsp_dz", 16'(rsp_dz), 16'(exp_dz));
    check_eq("alu_idle_in_done", {alu_operation, alu_ina, alu_inb[3:0]},
             {OP_IDLE, 8'd0, 4'd0});

    stable = 1'b1;
    for (int i = 0; i < hold_cyc; i++) begin
      cmd_valid = 1'b1;
      cmd_op    = 1'($urandom);
      cmd_a     = 8'($urandom);
      cmd_b     = 8'($urandom);
      if (cmd_ready !== 1'b0) stable = 1'b0;
      @(posedge clk); #1;
      cmd_valid = 1'b0;
      if (rsp_valid !== 1'b1 || rsp_hi !== exp_hi || rsp_lo !== exp_lo ||
          rsp_dz !== exp_dz || cmd_ready !== 1'b0) stable = 1'b0;
    end
    if (hold_cyc > 0) check_eq("hold_stable", 16'(stable), 16'd1);

    rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    check_eq("rsp_valid_after_take", 16'(rsp_valid), 16'd0);
    check_eq("cmd_ready_after_take", 16'(cmd_ready), 16'd1);
  endtask

  initial begin
    int n;
    logic       r_op;
    logic [7:0] r_a, r_b;

    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_op    = 1'b0;
    cmd_a     = '0;
    cmd_b     = '0;
    rsp_ready = 1'b0;

    repeat (3) @(posedge clk);
    #1;
    check_eq("reset_cmd_ready", 16'(cmd_ready), 16'd0);
    check_eq("reset_rsp", {7'd0, rsp_valid, rsp_dz, 7'd0}, 16'd0);
    check_eq("reset_rsp_data", {rsp_hi, rsp_lo}, 16'd0);
    check_eq("reset_alu", {alu_operation, alu_ina, alu_inb[3:0]}, {OP_IDLE, 12'd0});
    rst = 1'b0;
    #1;
    check_eq("cmd_ready_after_release", 16'(cmd_ready), 16'd1);

    // Directed cases.
    run_cmd(1'b0, 8'hFF, 8'hFF, 0);
    run_cmd(1'b0, 8'd13, 8'd11, 0);
    run_cmd(1'b1, 8'd200, 8'd7, 0);
    run_cmd(1'b1, 8'hFF, 8'h01, 0);
    run_cmd(1'b1, 8'h5A, 8'h00, 0);
    run_cmd(1'b0, 8'h80, 8'h02, 5);
    run_cmd(1'b1, 8'h07, 8'hC8, 0);

    // Reset asserted during RUN step 4.
    @(negedge clk);
    cmd_valid = 1'b1;
    cmd_op    = 1'b0;
    cmd_a     = 8'hA5;
    cmd_b     = 8'h3C;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check_eq("mid_run_opcode", 16'(alu_operation), 16'(OP_ADD));
    #2;
    rst = 1'b1;
    #1;
    check_eq("async_rst_cmd_ready", 16'(cmd_ready), 16'd0);
    check_eq("async_rst_rsp", {7'd0, rsp_valid, rsp_dz, 7'd0}, 16'd0);
    check_eq("async_rst_rsp_data", {rsp_hi, rsp_lo}, 16'd0);
    check_eq("async_rst_alu", {alu_operation, alu_ina, alu_inb[3:0]}, {OP_IDLE, 12'd0});
    @(posedge clk); #1;
    rst = 1'b0;
    #1;
    check_eq("cmd_ready_after_mid_rst", 16'(cmd_ready), 16'd1);
    run_cmd(1'b0, 8'h00, 8'h37, 0);

    // Random commands with occasional zero operands.
    for (int k = 0; k < 40; k++) begin
      r_op = 1'($urandom);
      r_a  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      r_b  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      n    = int'($urandom_range(0, 3));
      run_cmd(r_op, r_a, r_b, n);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
